// File: rtl/data_path_gen.sv
// Parametrised CPU data path: register file, flag-generating ALU, IR/CCR/PC/MAR/MDR,
// and a ready/valid memory handshake that stalls all register loads and aborts on timeout.
module data_path_gen #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int NREGS   = 4,
   parameter int TIMEOUT = 15,
   localparam int SEL_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ir_load,
   input  logic              ccr_load,
   input  logic              mar_load,
   input  logic              pc_load,
   input  logic              pc_inc,
   input  logic              reg_load,
   input  logic [SEL_W-1:0]  w_sel,
   input  logic [SEL_W-1:0]  a_sel,
   input  logic [SEL_W-1:0]  b_sel,
   input  logic [2:0]        alu_sel,
   input  logic [1:0]        from_sel,
   input  logic [1:0]        to_sel,
   input  logic              mem_rd_req,
   input  logic              mem_wr_req,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] to_memory,
   output logic [DATA_W-1:0] IR,
   output logic [3:0]        CCR,
   output logic              busy,
   output logic              mem_done,
   output logic              mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Handshake: mem_valid stays high from the cycle after an accepted request until
   // the edge at which mem_ready is sampled high (or the wait budget runs out).
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t              r_state, w_state_next;
   logic [DATA_W-1:0]   r_regs [NREGS];
   logic [DATA_W-1:0]   r_ir, r_mdr, r_to_memory;
   logic [ADDR_W-1:0]   r_pc, r_mar;
   logic [3:0]          r_ccr;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done, r_err;

   logic [DATA_W-1:0]   w_a, w_b, w_op_b, w_one, w_res;
   logic [DATA_W:0]     w_sum, w_diff;
   logic                w_n, w_z, w_v, w_c;
   logic [DATA_W-1:0]   w_pc_data, w_to_bus, w_from_bus;
   logic [ADDR_W-1:0]   w_bus_addr;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_busy, w_start, w_finish, w_abort;

   generate
      if (DATA_W >= ADDR_W) begin : g_wide_data
         assign w_pc_data  = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
         assign w_bus_addr = w_from_bus[ADDR_W-1:0];
      end else begin : g_wide_addr
         assign w_pc_data  = r_pc[DATA_W-1:0];
         assign w_bus_addr = {{(ADDR_W-DATA_W){1'b0}}, w_from_bus};
      end
   endgenerate

   assign w_a    = r_regs[a_sel];
   assign w_b    = r_regs[b_sel];
   assign w_one  = {{(DATA_W-1){1'b0}}, 1'b1};
   // INC/DEC reuse the adder and subtractor with a constant-one operand.
   assign w_op_b = (alu_sel == 3'd5 || alu_sel == 3'd6) ? w_one : w_b;
   assign w_sum  = {1'b0, w_a} + {1'b0, w_op_b};
   assign w_diff = {1'b0, w_a} - {1'b0, w_op_b};

   always_comb begin
      w_res = w_a;
      w_v   = 1'b0;
      w_c   = 1'b0;
      case (alu_sel)
         3'd0, 3'd5: begin
            w_res = w_sum[DATA_W-1:0];
            w_c   = w_sum[DATA_W];
            w_v   = (w_a[DATA_W-1] == w_op_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
         end
         3'd1, 3'd6: begin
            w_res = w_diff[DATA_W-1:0];
            w_c   = w_diff[DATA_W];
            w_v   = (w_a[DATA_W-1] != w_op_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
         end
         3'd2: w_res = w_a & w_b;
         3'd3: w_res = w_a | w_b;
         3'd4: w_res = w_a ^ w_b;
         default: w_res = w_a;
      endcase
      w_n = w_res[DATA_W-1];
      w_z = (w_res == '0);
   end

   always_comb begin
      case (to_sel)
         2'd0:    w_to_bus = w_pc_data;
         2'd1:    w_to_bus = w_a;
         2'd2:    w_to_bus = w_b;
         default: w_to_bus = '0;
      endcase
      case (from_sel)
         2'd0:    w_from_bus = w_res;
         2'd1:    w_from_bus = w_to_bus;
         2'd2:    w_from_bus = r_mdr;
         default: w_from_bus = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   assign w_cnt_next = r_cnt + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_finish     = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_wr_req) begin
               w_state_next = S_WRITE;
               w_start      = 1'b1;
            end else if (mem_rd_req) begin
               w_state_next = S_READ;
               w_start      = 1'b1;
            end
         end
         S_READ, S_WRITE: begin
            if (mem_ready) begin
               w_state_next = S_IDLE;
               w_finish     = 1'b1;
            end else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      w_busy    = (r_state != S_IDLE);
      mem_valid = w_busy;
      mem_we    = (r_state == S_WRITE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mdr       <= '0;
         r_to_memory <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_cnt <= '0;
            r_err <= 1'b0;
            if (mem_wr_req) r_to_memory <= w_to_bus;
         end else if (w_busy) begin
            r_cnt <= w_cnt_next;
         end
         if (w_finish && r_state == S_READ) r_mdr <= mem_rdata;
         if (w_abort) r_err <= 1'b1;
      end
   end

   // Every architectural register freezes while a memory transfer is outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ir  <= '0;
         r_ccr <= '0;
         r_mar <= '0;
         r_pc  <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (!w_busy) begin
         if (ir_load)  r_ir  <= w_from_bus;
         if (ccr_load) r_ccr <= {w_n, w_z, w_v, w_c};
         if (mar_load) r_mar <= w_bus_addr;
         if (pc_load)       r_pc <= w_bus_addr;
         else if (pc_inc)   r_pc <= r_pc + 1'b1;
         if (reg_load) r_regs[w_sel] <= w_from_bus;
      end
   end

   assign address   = r_mar;
   assign to_memory = r_to_memory;
   assign IR        = r_ir;
   assign CCR       = r_ccr;
   assign busy      = w_busy;
   assign mem_done  = r_done;
   assign mem_err   = r_err;

endmodule

// File: tb/tb_data_path_gen.sv
// Bench for data_path_gen: an integer-arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_data_path_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ir_load = 0, ccr_load = 0, mar_load = 0, pc_load = 0, pc_inc = 0, reg_load = 0;
  logic [1:0] w_sel = 0, a_sel = 0, b_sel = 0;
  logic [2:0] alu_sel = 0;
  logic [1:0] from_sel = 0, to_sel = 0;
  logic mem_rd_req = 0, mem_wr_req = 0, mem_ready = 0;
  logic [7:0] mem_rdata = 0;
  logic mem_valid, mem_we, busy, mem_done, mem_err;
  logic [7:0] address, to_memory, ir_q;
  logic [3:0] ccr_q;

  int n_checks = 0;
  int n_errs = 0;
  int busy_cyc = 0;
  int done_cyc = 0;

  data_path_gen #(.DATA_W(8), .ADDR_W(8), .NREGS(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ir_load(ir_load), .ccr_load(ccr_load), .mar_load(mar_load),
    .pc_load(pc_load), .pc_inc(pc_inc), .reg_load(reg_load),
    .w_sel(w_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel),
    .from_sel(from_sel), .to_sel(to_sel),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .address(address),
    .to_memory(to_memory), .IR(ir_q), .CCR(ccr_q), .busy(busy),
    .mem_done(mem_done), .mem_err(mem_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain integers, mode 0=idle 1=read 2=write
  int m_r[4];
  int m_ir, m_ccr, m_pc, m_mar, m_mdr, m_tom, m_mode, m_wait, m_done, m_err;
  int x_a, x_b, x_sa, x_sb, x_raw, x_sraw, x_res, x_tb, x_fb, x_c, x_v;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_ir = 0; m_ccr = 0; m_pc = 0; m_mar = 0; m_mdr = 0; m_tom = 0;
      m_mode = 0; m_wait = 0; m_done = 0; m_err = 0;
    end else begin
      x_a = m_r[a_sel];
      x_b = m_r[b_sel];
      x_sa = (x_a > 127) ? x_a - 256 : x_a;
      x_sb = (x_b > 127) ? x_b - 256 : x_b;
      x_c = 0; x_v = 0; x_sraw = 0;
      case (alu_sel)
        3'd0: begin x_raw = x_a + x_b; x_c = (x_raw > 255); x_sraw = x_sa + x_sb; end
        3'd1: begin x_raw = x_a - x_b; x_c = (x_a < x_b);  x_sraw = x_sa - x_sb; end
        3'd2: x_raw = x_a & x_b;
        3'd3: x_raw = x_a | x_b;
        3'd4: x_raw = x_a ^ x_b;
        3'd5: begin x_raw = x_a + 1; x_c = (x_raw > 255); x_sraw = x_sa + 1; end
        3'd6: begin x_raw = x_a - 1; x_c = (x_a == 0);    x_sraw = x_sa - 1; end
        default: x_raw = x_a;
      endcase
      if (alu_sel <= 3'd1 || alu_sel == 3'd5 || alu_sel == 3'd6)
        x_v = (x_sraw > 127 || x_sraw < -128);
      x_res = x_raw & 255;
      case (to_sel)
        2'd0: x_tb = m_pc;
        2'd1: x_tb = x_a;
        2'd2: x_tb = x_b;
        default: x_tb = 0;
      endcase
      case (from_sel)
        2'd0: x_fb = x_res;
        2'd1: x_fb = x_tb;
        2'd2: x_fb = m_mdr;
        default: x_fb = 0;
      endcase
      m_done = 0;
      if (m_mode == 0) begin
        if (ir_load) m_ir = x_fb;
        if (ccr_load) m_ccr = ((x_res > 127) ? 8 : 0) + ((x_res == 0) ? 4 : 0) + x_v * 2 + x_c;
        if (mar_load) m_mar = x_fb;
        if (pc_load) m_pc = x_fb;
        else if (pc_inc) m_pc = (m_pc + 1) % 256;
        if (reg_load) m_r[w_sel] = x_fb;
        if (mem_wr_req) begin
          m_mode = 2; m_tom = x_tb; m_wait = 0; m_err = 0;
        end else if (mem_rd_req) begin
          m_mode = 1; m_wait = 0; m_err = 0;
        end
      end else begin
        m_wait++;
        if (mem_ready) begin
          if (m_mode == 1) m_mdr = mem_rdata;
          m_mode = 0;
          m_done = 1;
        end else if (m_wait >= 15) begin
          m_mode = 0;
          m_err = 1;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    chk("mem_valid", mem_valid, m_mode != 0);
    chk("mem_we", mem_we, m_mode == 2);
    chk("busy", busy, m_mode != 0);
    chk("address", address, m_mar);
    chk("to_memory", to_memory, m_tom);
    chk("IR", ir_q, m_ir);
    chk("CCR", ccr_q, m_ccr);
    chk("mem_done", mem_done, m_done);
    chk("mem_err", mem_err, m_err);
    if (busy === 1'b1) busy_cyc++;
    if (mem_done === 1'b1) done_cyc++;
  end

  // driver tasks
  task automatic clear_strobes();
    ir_load = 0; ccr_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0; reg_load = 0;
    mem_rd_req = 0; mem_wr_req = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic mem_read(input logic [7:0] d, input int n);
    @(negedge clk);
    mem_rd_req = 1;
    @(negedge clk);
    mem_rd_req = 0;
    repeat (n) @(negedge clk);
    mem_ready = 1;
    mem_rdata = d;
    tick();
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    mem_read(val, 0);
    from_sel = 2; w_sel = idx; reg_load = 1;
    tick();
  endtask

  task automatic read_reg_ir(input logic [1:0] idx);
    to_sel = 1; a_sel = idx; from_sel = 1; ir_load = 1;
    tick();
  endtask

  task automatic read_pc_ir();
    to_sel = 0; from_sel = 1; ir_load = 1;
    tick();
  endtask

  initial begin
    // reset and idle
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_IR", ir_q, 0);
    chk("rst_CCR", ccr_q, 0);
    chk("rst_err", mem_err, 0);
    tick();

    // asynchronous reset mid-READ
    @(negedge clk); mem_rd_req = 1;
    @(negedge clk); mem_rd_req = 0;
    chk("midrd_valid_before", mem_valid, 1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("midrd_valid_async", mem_valid, 0);
    chk("midrd_busy_async", busy, 0);
    @(negedge clk);
    reset = 1;
    tick();

    // ADD 7F+01 -> 80, NZVC=1010
    load_reg(0, 8'h7F);
    load_reg(1, 8'h01);
    a_sel = 0; b_sel = 1; alu_sel = 0; from_sel = 0; w_sel = 2; reg_load = 1; ccr_load = 1;
    tick();
    chk("add_ccr", ccr_q, 4'b1010);
    read_reg_ir(2);
    chk("add_result", ir_q, 8'h80);

    // DEC 00 -> FF, NZVC=1001
    load_reg(0, 8'h00);
    a_sel = 0; alu_sel = 6; from_sel = 0; w_sel = 3; reg_load = 1; ccr_load = 1;
    tick();
    chk("dec_ccr", ccr_q, 4'b1001);
    read_reg_ir(3);
    chk("dec_result", ir_q, 8'hFF);

    // SUB 05-05 -> 00, NZVC=0100
    load_reg(0, 8'h05);
    load_reg(1, 8'h05);
    a_sel = 0; b_sel = 1; alu_sel = 1; from_sel = 0; w_sel = 3; reg_load = 1; ccr_load = 1;
    tick();
    chk("sub_ccr", ccr_q, 4'b0100);
    read_reg_ir(3);
    chk("sub_result", ir_q, 8'h00);

    // read from MAR=10 with three wait cycles
    load_reg(2, 8'h10);
    to_sel = 1; a_sel = 2; from_sel = 1; mar_load = 1;
    tick();
    chk("mar_load", address, 8'h10);
    busy_cyc = 0; done_cyc = 0;
    mem_read(8'hA5, 3);
    chk("rd_busy_cycles", busy_cyc, 4);
    chk("rd_done_pulse", mem_done, 1);
    chk("rd_done_count", done_cyc, 1);
    from_sel = 2; ir_load = 1;
    tick();
    chk("rd_mdr_to_ir", ir_q, 8'hA5);
    chk("rd_done_cleared", mem_done, 0);

    // write captures to_bus; stalled loads and pc_inc have no effect; write wins over read
    load_reg(2, 8'h3C);
    @(negedge clk);
    to_sel = 1; a_sel = 2; mem_wr_req = 1; mem_rd_req = 1;
    @(negedge clk);
    mem_wr_req = 0; mem_rd_req = 0;
    a_sel = 0; reg_load = 1; w_sel = 2; from_sel = 3; pc_inc = 1;
    chk("wr_we", mem_we, 1);
    chk("wr_data", to_memory, 8'h3C);
    repeat (2) @(negedge clk);
    chk("wr_data_held", to_memory, 8'h3C);
    mem_ready = 1;
    tick();
    chk("wr_done", mem_done, 1);
    chk("wr_we_dropped", mem_we, 0);
    read_reg_ir(2);
    chk("wr_stall_reg", ir_q, 8'h3C);
    read_pc_ir();
    chk("wr_stall_pc", ir_q, 8'h00);

    // timeout with mem_ready held low
    busy_cyc = 0; done_cyc = 0;
    @(negedge clk); mem_rd_req = 1;
    @(negedge clk); mem_rd_req = 0;
    repeat (20) @(negedge clk);
    chk("to_busy_cycles", busy_cyc, 15);
    chk("to_err", mem_err, 1);
    chk("to_no_done", done_cyc, 0);
    chk("to_busy_low", busy, 0);
    mem_read(8'h55, 0);
    chk("to_err_cleared", mem_err, 0);

    // PC wrap, simultaneous loads, pc_load over pc_inc
    load_reg(0, 8'hFF);
    to_sel = 1; a_sel = 0; from_sel = 1; pc_load = 1; mar_load = 1;
    tick();
    chk("multi_mar", address, 8'hFF);
    pc_inc = 1;
    tick();
    read_pc_ir();
    chk("pc_wrap", ir_q, 8'h00);
    load_reg(1, 8'h42);
    to_sel = 1; a_sel = 1; from_sel = 1; pc_load = 1; pc_inc = 1;
    tick();
    read_pc_ir();
    chk("pc_load_prio", ir_q, 8'h42);

    // XOR and INC overflow exercised through the model only
    load_reg(0, 8'h7F);
    a_sel = 0; b_sel = 1; alu_sel = 5; ccr_load = 1;
    tick();
    chk("inc_ccr", ccr_q, 4'b1010);
    alu_sel = 4; ccr_load = 1;
    tick();
    chk("xor_ccr", ccr_q, 4'b0000);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/data_path_gen.md
Name: data_path_gen

Overview:
Parametrised next-generation CPU data path. It replaces the fixed two-accumulator 8-bit data path with a configurable-width design. Additions over that design: an N-entry register file, an internal ALU with flag generation, a memory data register (MDR), and a ready/valid memory handshake with stall and timeout. It sits between the control unit (which drives the strobes and reads IR/CCR/busy) and the memory model.

Parameters:
DATA_W, 8, datapath and register width (>=4)
ADDR_W, 8, address/PC/MAR width (>=4)
NREGS, 4, register-file entries (power of 2, >=2)
TIMEOUT, 15, max cycles waiting for mem_ready before abort (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ir_load  in  1  IR <= from_bus
ccr_load  in  1  CCR <= ALU NZVC
mar_load  in  1  MAR <= from_bus[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W)
pc_load  in  1  PC <= from_bus (same width rule as MAR)
pc_inc  in  1  PC <= PC+1
reg_load  in  1  R[w_sel] <= from_bus
w_sel, a_sel, b_sel  in  log2(NREGS) each  write / ALU-A / ALU-B register selects
alu_sel  in  3  ALU operation
from_sel  in  2  from_bus source
to_sel  in  2  to_bus source
mem_rd_req  in  1  start read at MAR
mem_wr_req  in  1  start write of to_bus at MAR
mem_ready  in  1  memory completes transfer
mem_rdata  in  DATA_W  read data
mem_valid  out  1  transaction outstanding
mem_we  out  1  1=write, valid with mem_valid
address  out  ADDR_W  = MAR
to_memory  out  DATA_W  write data captured at request
IR  out  DATA_W  instruction register
CCR  out  4  {N,Z,V,C}
busy  out  1  FSM not IDLE
mem_done  out  1  one-cycle pulse on completion
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, active-low): IR, MAR, PC, all R[i], MDR, to_memory = 0; CCR=0; FSM=IDLE; mem_valid=mem_we=busy=mem_done=mem_err=0, forced immediately and also mid-transaction.
- to_bus (combinational): 0 PC (zero-ext/truncated to DATA_W), 1 R[a_sel], 2 R[b_sel], 3 zero.
- from_bus (combinational): 0 ALU result, 1 to_bus, 2 MDR, 3 zero.
- ALU (combinational), A=R[a_sel], B=R[b_sel], alu_sel:
  - 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 INC A; 6 DEC A; 7 PASS A.
  - N=result MSB; Z=(result==0).
  - ADD/INC: C=carry out; V=signed overflow.
  - SUB/DEC: C=borrow (A<B unsigned; for DEC, A==0); V=signed overflow.
  - Logic ops and PASS: V=C=0.
- Registers update on posedge clk only when busy=0; all load/inc strobes are ignored while busy=1 (stall).
- PC: pc_load has priority over pc_inc; increment wraps modulo 2^ADDR_W.
- Multiple loads in one cycle are legal; each destination takes the same from_bus value.
- FSM states IDLE, READ, WRITE:
  - IDLE: mem_wr_req -> WRITE (priority if both requests are set); mem_rd_req -> READ.
  - On the request edge: to_memory <= to_bus (writes only), wait counter cleared.
  - READ/WRITE: mem_valid=1; mem_we=1 in WRITE; counter increments each cycle.
  - mem_ready=1 sampled: -> IDLE, mem_done pulses next cycle. READ also sets MDR <= mem_rdata.
  - Counter reaches TIMEOUT without ready: -> IDLE, mem_err<=1, no MDR update, no mem_done.
  - Requests while busy are ignored.
  - Any accepted request clears mem_err.
- Latency: request cycle k -> mem_valid from cycle k+1. Ready at cycle k+1+n -> busy low and MDR valid from cycle k+2+n.

Test Plan:
1. Reset then idle: all outputs 0; assert reset low mid-READ -> mem_valid/busy drop to 0 with no clock edge.
2. R0=8'h7F, R1=8'h01, alu_sel=0, from_sel=0, reg_load w_sel=2, ccr_load -> R2=8'h80, CCR=4'b1010 (N=1,Z=0,V=1,C=0).
3. R0=8'h00, alu_sel=6 (DEC) -> result 8'hFF, CCR=4'b1001; SUB with A=B=8'h05 -> result 0, CCR=4'b0100.
4. MAR=8'h10, mem_rd_req; ready after 3 wait cycles with mem_rdata=8'hA5 -> busy 4 cycles; mem_done pulse; MDR=8'hA5; from_sel=2, ir_load -> IR=8'hA5.
5. mem_wr_req with to_sel=1 (R[a_sel]=8'h3C), then change R[a_sel] -> to_memory stays 8'h3C, mem_we=1 until ready; pc_inc during busy has no effect.
6. mem_rd_req with mem_ready held 0 -> after TIMEOUT=15 cycles FSM returns to IDLE, mem_err=1, no mem_done; next request clears mem_err. PC=8'hFF with pc_inc -> 8'h00; pc_load and pc_inc together -> loaded value.
